// File: rtl/demosaic_pkg.sv
// Shared definitions for the demosaic/remosaic family: CFA phase encoding,
// default sample width and the Bayer channel-select helper.
package demosaic_pkg;

  localparam int DW_DEFAULT = 10;

  typedef enum logic [1:0] {
    CFA_RGGB = 2'd0,
    CFA_GRBG = 2'd1,
    CFA_GBRG = 2'd2,
    CFA_BGGR = 2'd3
  } cfa_phase_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  // Phase bit 0 flips the column parity, bit 1 flips the row parity.
  function automatic chan_e chan_sel(input logic col0, input logic row0,
                                     input logic [1:0] phase);
    logic pc;
    logic pr;
    pc = col0 ^ phase[0];
    pr = row0 ^ phase[1];
    if (!pc && !pr) return CH_R;
    if (pc && pr)   return CH_B;
    return CH_G;
  endfunction

endpackage

// File: rtl/bayer_pos_counter.sv
// Column/row tracker for the remosaic stream: sof realignment, frame wrap,
// frame_done pulse and sticky sof/eol consistency errors.
module bayer_pos_counter
  import demosaic_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic clk,
  input  logic rst,
  input  logic beat_i,
  input  logic sof_i,
  input  logic eol_i,
  input  logic err_clr_i,
  output logic col0_o,
  output logic row0_o,
  output logic is_origin_o,
  output logic is_eol_o,
  output logic frame_done_o,
  output logic err_sof_o,
  output logic err_eol_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, col_use;
  logic [RW-1:0] row_q, row_d, row_use;
  logic          frame_done_q, frame_done_d;
  logic          err_sof_q, err_sof_d;
  logic          err_eol_q, err_eol_d;
  logic          at_origin;
  logic          is_eol;

  always_comb begin
    at_origin    = (col_q == '0) && (row_q == '0);
    col_use      = sof_i ? '0 : col_q;
    row_use      = sof_i ? '0 : row_q;
    is_eol       = (col_use == COL_LAST);
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    // Set wins over clear so an error in the clearing cycle is not lost.
    err_sof_d    = err_sof_q & ~err_clr_i;
    err_eol_d    = err_eol_q & ~err_clr_i;
    if (beat_i) begin
      if (is_eol) begin
        col_d = '0;
        if (row_use == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_use + RW'(1);
        end
      end else begin
        col_d = col_use + CW'(1);
        row_d = row_use;
      end
      if (sof_i && !at_origin) err_sof_d = 1'b1;
      if (eol_i != is_eol)     err_eol_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
      err_eol_q    <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      err_sof_q    <= err_sof_d;
      err_eol_q    <= err_eol_d;
    end
  end

  assign col0_o       = col_use[0];
  assign row0_o       = row_use[0];
  assign is_origin_o  = (col_use == '0) && (row_use == '0);
  assign is_eol_o     = is_eol;
  assign frame_done_o = frame_done_q;
  assign err_sof_o    = err_sof_q;
  assign err_eol_o    = err_eol_q;

endmodule

// File: rtl/bayer_remosaic_stream.sv
// RGB to single-channel Bayer remosaic with regenerated sof/eol sideband
// and a one-deep valid/ready output register.
module bayer_remosaic_stream
  import demosaic_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int CFA_PHASE = CFA_RGGB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_r,
  input  logic [DW-1:0] s_g,
  input  logic [DW-1:0] s_b,
  input  logic          s_sof,
  input  logic          s_eol,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_sof,
  output logic          m_eol,
  output logic          frame_done,
  output logic          err_sof,
  output logic          err_eol,
  input  logic          err_clr
);

  localparam logic [1:0] PHASE = 2'(CFA_PHASE);

  logic          beat;
  logic          col0, row0, is_origin, is_eol;
  chan_e         ch;
  logic [DW-1:0] pix;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_sof_q, m_sof_d;
  logic          m_eol_q, m_eol_d;

  assign s_ready = !m_valid_q || m_ready;
  assign beat    = s_valid && s_ready;

  bayer_pos_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .beat_i      (beat),
    .sof_i       (s_sof),
    .eol_i       (s_eol),
    .err_clr_i   (err_clr),
    .col0_o      (col0),
    .row0_o      (row0),
    .is_origin_o (is_origin),
    .is_eol_o    (is_eol),
    .frame_done_o(frame_done),
    .err_sof_o   (err_sof),
    .err_eol_o   (err_eol)
  );

  always_comb begin
    ch = chan_sel(col0, row0, PHASE);
    case (ch)
      CH_R:    pix = s_r;
      CH_G:    pix = s_g;
      default: pix = s_b;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sof_d   = m_sof_q;
    m_eol_d   = m_eol_q;
    if (beat) begin
      m_valid_d = 1'b1;
      m_data_d  = pix;
      m_sof_d   = is_origin;
      m_eol_d   = is_eol;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sof_q   <= m_sof_d;
      m_eol_q   <= m_eol_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sof   = m_sof_q;
  assign m_eol   = m_eol_q;

endmodule

// File: tb/tb_bayer_remosaic_stream.sv
// Bench for bayer_remosaic_stream: RGGB and BGGR instances share one stimulus
// and are checked against a position/pattern-string reference model.
module tb_bayer_remosaic_stream;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst, s_valid, s_sof, s_eol, m_ready, err_clr;
  logic [DW-1:0] s_r, s_g, s_b;

  logic s_ready0, m_valid0, m_sof0, m_eol0, fd0, esof0, eeol0;
  logic s_ready3, m_valid3, m_sof3, m_eol3, fd3, esof3, eeol3;
  logic [DW-1:0] m_data0, m_data3;

  always #5 clk = ~clk;

  bayer_remosaic_stream #(.DW(DW), .IMG_W(W), .IMG_H(H), .CFA_PHASE(0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
    .s_r(s_r), .s_g(s_g), .s_b(s_b), .s_sof(s_sof), .s_eol(s_eol),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
    .m_sof(m_sof0), .m_eol(m_eol0), .frame_done(fd0),
    .err_sof(esof0), .err_eol(eeol0), .err_clr(err_clr));

  bayer_remosaic_stream #(.DW(DW), .IMG_W(W), .IMG_H(H), .CFA_PHASE(3)) dut3 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready3),
    .s_r(s_r), .s_g(s_g), .s_b(s_b), .s_sof(s_sof), .s_eol(s_eol),
    .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3),
    .m_sof(m_sof3), .m_eol(m_eol3), .frame_done(fd3),
    .err_sof(esof3), .err_eol(eeol3), .err_clr(err_clr));

  typedef struct {int d0; int d3; bit sof; bit eol;} exp_t;

  exp_t q[$];
  int   log0[$];
  int   log3[$];
  int   col_m, row_m, fd_cnt;
  bit   esof_m, eeol_m, fd_m;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input int ph, input int uc, input int ur);
    string pat;
    byte   c;
    pat = "RGGBGRBGGBRGBGGR";
    c = pat[ph*4 + (ur % 2)*2 + (uc % 2)];
    if (c == "R") return int'(s_r);
    if (c == "G") return int'(s_g);
    return int'(s_b);
  endfunction

  task automatic model_reset();
    q.delete();
    col_m = 0; row_m = 0;
    esof_m = 0; eeol_m = 0; fd_m = 0;
  endtask

  // Checks outputs at the falling edge, then advances the model by the
  // handshakes that the next rising edge will complete.
  task automatic step(output bit acc);
    bit   exp_ready, set_s, set_e;
    int   uc, ur, lin;
    exp_t e;
    @(negedge clk);
    exp_ready = (q.size() == 0) || m_ready;
    chk("s_ready0", int'(s_ready0), int'(exp_ready));
    chk("s_ready3", int'(s_ready3), int'(exp_ready));
    chk("m_valid0", int'(m_valid0), int'(q.size() != 0));
    chk("m_valid3", int'(m_valid3), int'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_data0", int'(m_data0), q[0].d0);
      chk("m_data3", int'(m_data3), q[0].d3);
      chk("m_sof0", int'(m_sof0), int'(q[0].sof));
      chk("m_sof3", int'(m_sof3), int'(q[0].sof));
      chk("m_eol0", int'(m_eol0), int'(q[0].eol));
      chk("m_eol3", int'(m_eol3), int'(q[0].eol));
      if (m_ready) begin
        log0.push_back(int'(m_data0));
        log3.push_back(int'(m_data3));
        void'(q.pop_front());
      end
    end
    chk("frame_done0", int'(fd0), int'(fd_m));
    chk("frame_done3", int'(fd3), int'(fd_m));
    chk("err_sof0", int'(esof0), int'(esof_m));
    chk("err_sof3", int'(esof3), int'(esof_m));
    chk("err_eol0", int'(eeol0), int'(eeol_m));
    chk("err_eol3", int'(eeol3), int'(eeol_m));
    if (fd0) fd_cnt++;
    fd_m = 0;
    set_s = 0;
    set_e = 0;
    acc = s_valid && exp_ready && !rst;
    if (acc) begin
      if (s_sof) begin
        set_s = (col_m != 0) || (row_m != 0);
        uc = 0; ur = 0;
      end else begin
        uc = col_m; ur = row_m;
      end
      set_e = (s_eol != (uc == W - 1));
      e.d0 = pick(0, uc, ur);
      e.d3 = pick(3, uc, ur);
      e.sof = (uc == 0) && (ur == 0);
      e.eol = (uc == W - 1);
      q.push_back(e);
      lin = ur*W + uc + 1;
      if (lin == W*H) begin
        fd_m = 1;
        lin = 0;
      end
      col_m = lin % W;
      row_m = lin / W;
    end
    if (!rst) begin
      esof_m = set_s | (esof_m & !err_clr);
      eeol_m = set_e | (eeol_m & !err_clr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input int g, input int b, input bit sof, input bit flip);
    s_r = DW'(r); s_g = DW'(g); s_b = DW'(b);
    s_sof = sof;
    s_eol = (((sof ? 0 : col_m) == W - 1) ? 1'b1 : 1'b0) ^ flip;
    s_valid = 1'b1;
  endtask

  task automatic send(input int r, input int g, input int b, input bit sof, input bit flip);
    bit acc;
    int n;
    drive(r, g, b, sof, flip);
    acc = 0;
    n = 0;
    while (!acc && n < 20) begin
      step(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  task automatic pulse_clr();
    bit acc;
    err_clr = 1'b1;
    step(acc);
    err_clr = 1'b0;
    step(acc);
  endtask

  task automatic realign();
    int n;
    n = 0;
    while (!(col_m == 0 && row_m == 0) && n < W*H) begin
      send(10 + n, 20 + n, 30 + n, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic check_frame(input string tag);
    int e0[8] = '{100, 201, 102, 203, 204, 305, 206, 307};
    int e3[8] = '{300, 201, 302, 203, 204, 105, 206, 107};
    chk({tag, "_count"}, log0.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_rggb"}, (i < log0.size()) ? log0[i] : -1, e0[i]);
      chk({tag, "_bggr"}, (i < log3.size()) ? log3[i] : -1, e3[i]);
    end
  endtask

  initial begin
    bit acc;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    m_ready = 1'b1; err_clr = 1'b0;
    s_r = '0; s_g = '0; s_b = '0;
    model_reset();
    fd_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", int'(m_valid0 | m_valid3), 0);
    chk("rst_m_data", int'(m_data0 | m_data3), 0);
    chk("rst_m_sof", int'(m_sof0 | m_sof3), 0);
    chk("rst_m_eol", int'(m_eol0 | m_eol3), 0);
    chk("rst_frame_done", int'(fd0 | fd3), 0);
    chk("rst_errs", int'(esof0 | esof3 | eeol0 | eeol3), 0);
    rst = 1'b0;

    // Basic frame in both phases
    log0.delete(); log3.delete(); fd_cnt = 0;
    for (int i = 0; i < 8; i++) send(100 + i, 200 + i, 300 + i, 1'b0, 1'b0);
    idle(2);
    check_frame("frame");
    chk("frame_done_pulses", fd_cnt, 1);

    // Backpressure after beat 2
    log0.delete(); log3.delete();
    for (int i = 0; i < 3; i++) send(100 + i, 200 + i, 300 + i, 1'b0, 1'b0);
    m_ready = 1'b0;
    drive(103, 203, 303, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(acc);
      chk("stall_accept", int'(acc), 0);
      chk("stall_hold", int'(m_data0), 102);
      chk("stall_s_ready", int'(s_ready0), 0);
    end
    m_ready = 1'b1;
    for (int i = 3; i < 8; i++) send(100 + i, 200 + i, 300 + i, 1'b0, 1'b0);
    idle(2);
    check_frame("stall");

    // Mid-frame sof realigns to the origin
    for (int i = 0; i < 5; i++) send(100 + i, 200 + i, 300 + i, 1'b0, 1'b0);
    send(105, 205, 305, 1'b1, 1'b0);
    idle(1);
    chk("sof_err_set", int'(esof0), 1);
    chk("sof_next_col", col_m, 1);
    send(106, 206, 306, 1'b0, 1'b0);
    pulse_clr();
    chk("sof_err_clr", int'(esof0), 0);
    realign();

    // Early and missing eol
    send(100, 200, 300, 1'b0, 1'b0);
    send(101, 201, 301, 1'b0, 1'b1);
    idle(1);
    chk("eol_early_err", int'(eeol0), 1);
    for (int i = 2; i < 8; i++) send(100 + i, 200 + i, 300 + i, 1'b0, 1'b0);
    pulse_clr();
    chk("eol_clr", int'(eeol0), 0);
    for (int i = 0; i < 3; i++) send(100 + i, 200 + i, 300 + i, 1'b0, 1'b0);
    send(103, 203, 303, 1'b0, 1'b1);
    idle(1);
    chk("eol_missing_err", int'(eeol0), 1);
    pulse_clr();
    realign();

    // Reset mid-frame with output valid
    for (int i = 0; i < 4; i++) send(100 + i, 200 + i, 300 + i, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid0", int'(m_valid0), 0);
    chk("async_rst_valid3", int'(m_valid3), 0);
    model_reset();
    step(acc);
    rst = 1'b0;
    send(104, 204, 304, 1'b0, 1'b0);
    idle(1);
    chk("post_rst_col", col_m, 1);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      s_valid = ($urandom % 4) != 0;
      m_ready = ($urandom % 4) != 0;
      s_r = DW'($urandom); s_g = DW'($urandom); s_b = DW'($urandom);
      s_sof = ($urandom % 40) == 0;
      s_eol = (((s_sof ? 0 : col_m) == W - 1) ? 1'b1 : 1'b0) ^ (($urandom % 30) == 0);
      err_clr = ($urandom % 25) == 0;
      step(acc);
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; err_clr = 1'b0; m_ready = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
